alu_word_sequencer: RTL and testbench

- Master-side driver for the ALU operand/function/flag interface.
- Accepts a multi-word request of WORDS x WIDTH bits and issues the ALU once per word, least-significant word first.
- Chains flags between words so arithmetic wider than the ALU works, then presents the assembled result and final flags on a response handshake.
- Sits between the instruction/control path and the ALU datapath.

---
 rtl/alu_word_sequencer_if.sv | 32 +++
 rtl/alu_word_sequencer.sv | 73 +++++++
 tb/tb_alu_word_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_word_sequencer_if.sv
// alu_word_sequencer_if: request, ALU and response bus bundle for the word sequencer
interface alu_word_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic [3:0]             req_op;
  logic [WIDTH*WORDS-1:0] req_a;
  logic [WIDTH*WORDS-1:0] req_b;
  logic [3:0]             req_flags;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [3:0]             alu_func_op;
  logic [3:0]             alu_i_flags;
  logic                   alu_oe;
  logic [WIDTH-1:0]       alu_y;
  logic [3:0]             alu_o_flags;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH*WORDS-1:0] rsp_y;
  logic [3:0]             rsp_flags;
  logic                   busy;
  modport master (
    input  req_valid, req_op, req_a, req_b, req_flags, alu_y, alu_o_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_func_op, alu_i_flags, alu_oe, rsp_valid, rsp_y, rsp_flags, busy
  );
  modport slave (
    output req_valid, req_op, req_a, req_b, req_flags, alu_y, alu_o_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_func_op, alu_i_flags, alu_oe, rsp_valid, rsp_y, rsp_flags, busy
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: drives a WIDTH-bit ALU once per word to build WORDS*WIDTH-bit results; ALU_SEQ_ZCHAIN_EN makes Z cover all words
module alu_word_sequencer #(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
) (
  input logic clk,
  input logic rst,
  alu_word_sequencer_if.master bus
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH*WORDS-1:0] a_q, b_q, y_q;
  logic [3:0] op_q, f_q, chain_q;
  logic last, drive, z_out;
  assign last = idx == IW'(WORDS - 1);
`ifdef ALU_SEQ_ZCHAIN_EN
  logic z_q;
  // Z accumulates across words so only an all-zero wide result reports zero
  always_ff @(posedge clk)
    if (rst) z_q <= 1'b0;
    else if (state == IDLE && bus.req_valid) z_q <= 1'b1;
    else if (state == SAMPLE) z_q <= z_q & bus.alu_o_flags[0];
  assign z_out = z_q;
`else
  assign z_out = chain_q[0];
`endif
  // State register, request latch, per-word result capture and flag chain
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
      chain_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        op_q <= bus.req_op;
        f_q  <= bus.req_flags;
        idx  <= '0;
      end
      if (state == SAMPLE) begin
        y_q[idx*WIDTH +: WIDTH] <= bus.alu_y;
        chain_q <= bus.alu_o_flags;
        if (!last) idx <= idx + 1'b1;
      end
    end
  // Next-state and output decode; ALU drives are only live in SETUP/SAMPLE
  always_comb begin
    state_n = state == IDLE   ? (bus.req_valid ? SETUP : IDLE) :
              state == SETUP  ? SAMPLE :
              state == SAMPLE ? (last ? DONE : SETUP) :
                                (bus.rsp_ready ? IDLE : DONE);
    drive           = state == SETUP || state == SAMPLE;
    bus.req_ready   = state == IDLE && !rst;
    bus.alu_a       = drive ? a_q[idx*WIDTH +: WIDTH] : '0;
    bus.alu_b       = drive ? b_q[idx*WIDTH +: WIDTH] : '0;
    bus.alu_func_op = drive ? op_q : '0;
    bus.alu_i_flags = drive ? (idx == '0 ? f_q : chain_q) : '0;
    bus.alu_oe      = state == SAMPLE;
    bus.rsp_valid   = state == DONE;
    bus.rsp_y       = y_q;
    bus.rsp_flags   = {chain_q[3:1], z_out};
    bus.busy        = state != IDLE;
  end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: scoreboard bench with a carry/borrow-chaining ALU model
module tb_alu_word_sequencer;
  localparam int WIDTH = 8;
  localparam int WORDS = 2;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  typedef struct packed {logic [15:0] y; logic [3:0] f;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_word_sequencer_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();
  alu_word_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int oe_cnt = 0;
  int bad_oe = 0;
  logic prev_oe = 1'b0;
  logic [3:0] if_log[2];
  logic [3:0] cur_flags;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [8:0] s8;
  logic v8;
  always_comb begin
    s8 = bus.alu_func_op == OP_SUB ?
         {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - 9'(bus.alu_i_flags[1]) :
         {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 9'(bus.alu_i_flags[1]);
    v8 = bus.alu_func_op == OP_SUB ?
         (bus.alu_a[7] != bus.alu_b[7]) && (s8[7] != bus.alu_a[7]) :
         (bus.alu_a[7] == bus.alu_b[7]) && (s8[7] != bus.alu_a[7]);
    bus.alu_y       = bus.alu_oe ? s8[7:0] : 8'h5A;
    bus.alu_o_flags = bus.alu_oe ? {v8, s8[7], s8[8], s8[7:0] == 8'h00} : 4'b1010;
  end
  always @(negedge clk) begin
    if (bus.alu_oe) begin
      if (oe_cnt < 2) if_log[oe_cnt[0]] = bus.alu_i_flags;
      oe_cnt++;
      if (prev_oe || !bus.busy || bus.rsp_valid) bad_oe++;
    end
    prev_oe = bus.alu_oe;
  end
  function automatic exp_t ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic v, z;
    exp_t e;
    s = op == OP_SUB ? {1'b0, a} - {1'b0, b} - 17'(f[1]) : {1'b0, a} + {1'b0, b} + 17'(f[1]);
    v = op == OP_SUB ? (a[15] != b[15]) && (s[15] != a[15]) : (a[15] == b[15]) && (s[15] != a[15]);
`ifdef ALU_SEQ_ZCHAIN_EN
    z = s[15:0] == 16'h0;
`else
    z = s[15:8] == 8'h0;
`endif
    e.y = s[15:0];
    e.f = {v, s[15], s[16], z};
    return e;
  endfunction
  task automatic start_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f, output int w);
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_flags = f;
    bus.req_valid = 1'b1;
    cur_flags = f;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk);
      #1 w++;
    end
    chk("req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    sb.push_back(ref_op(op, a, b, f));
    oe_cnt = 0;
  endtask
  task automatic wait_rsp(input string tag);
    int n = 0;
    exp_t e;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(2 * WORDS));
    chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    e = sb.pop_front();
    chk({tag, "_rsp_y"}, 64'(bus.rsp_y), 64'(e.y));
    chk({tag, "_rsp_flags"}, 64'(bus.rsp_flags), 64'(e.f));
    chk({tag, "_oe_pulses"}, 64'(oe_cnt), 64'(WORDS));
    chk({tag, "_word0_iflags"}, 64'(if_log[0]), 64'(cur_flags));
  endtask
  task automatic ack(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk({tag, "_after_ack"}, 64'({bus.rsp_valid, bus.busy, bus.req_ready}), 64'(3'b001));
  endtask
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int w;
    start_req(op, a, b, f, w);
    wait_rsp(tag);
    ack(tag);
  endtask
  initial begin
    int w;
    logic seen;
    logic [15:0] held_y;
    logic [3:0] held_f;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_flags = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.busy, bus.alu_oe, bus.alu_a, bus.alu_b,
                             bus.alu_func_op, bus.alu_i_flags, bus.rsp_y, bus.rsp_flags}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("idle_ready", 64'({bus.req_ready, bus.busy}), 64'(2'b10));
    run_op("add_carry", OP_ADD, 16'h00FF, 16'h0001, 4'h0);
    chk("add_carry_w0_cin", 64'(if_log[0][1]), 64'd0);
    chk("add_carry_w1_cin", 64'(if_log[1][1]), 64'd1);
    chk("add_carry_y", 64'(bus.rsp_y), 64'h0100);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 4'h0);
    chk("add_wrap_cz", 64'({bus.rsp_flags[1], bus.rsp_flags[0]}), 64'(2'b11));
    run_op("add_wrap2", OP_ADD, 16'hFF00, 16'h0100, 4'h0);
    chk("add_wrap2_y", 64'(bus.rsp_y), 64'h0000);
    run_op("add_lowz", OP_ADD, 16'h0001, 16'h0000, 4'h0);
`ifdef ALU_SEQ_ZCHAIN_EN
    chk("add_lowz_z", 64'(bus.rsp_flags[0]), 64'd0);
`else
    chk("add_lowz_z", 64'(bus.rsp_flags[0]), 64'd1);
`endif
    start_req(OP_ADD, 16'h1234, 16'h4321, 4'h0, w);
    wait_rsp("bp_first");
    held_y = bus.rsp_y;
    held_f = bus.rsp_flags;
    bus.req_op = OP_SUB;
    bus.req_a = 16'h8000;
    bus.req_b = 16'h0001;
    bus.req_flags = 4'h0;
    bus.req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 chk("bp_hold", 64'({bus.rsp_y, bus.rsp_flags, bus.rsp_valid, bus.req_ready}), 64'({held_y, held_f, 1'b1, 1'b0}));
    end
    ack("bp_first");
    start_req(OP_SUB, 16'h8000, 16'h0001, 4'h0, w);
    chk("bp_accept_wait", 64'(w), 64'd0);
    wait_rsp("bp_second");
    ack("bp_second");
    start_req(OP_SUB, 16'h0300, 16'h0001, 4'h0, w);
    @(posedge clk);
    #1 chk("in_sample", 64'(bus.alu_oe), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("mid_reset_outputs", {bus.req_ready, bus.rsp_valid, bus.busy, bus.alu_oe, bus.alu_a, bus.alu_b,
                                 bus.alu_func_op, bus.alu_i_flags, bus.rsp_y, bus.rsp_flags}, 64'd0);
    void'(sb.pop_back());
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 seen |= bus.rsp_valid;
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    run_op("sub_after_reset", OP_SUB, 16'h0100, 16'h0001, 4'h0);
    chk("sub_after_reset_y", 64'(bus.rsp_y), 64'h00FF);
    chk("sub_after_reset_c", 64'(bus.rsp_flags[1]), 64'd0);
    for (int i = 0; i < 6; i++)
      run_op("rand", i[0] ? OP_SUB : OP_ADD, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    chk("oe_protocol", 64'(bad_oe), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
